// File: rtl/gray_count_bank_pkg.sv
// rtl/gray_count_bank_pkg.sv - shared limits, step encoding and gray-code helpers for gray_count_bank
package gray_count_bank_pkg;

  localparam int NUM_CH_MAX      = 16;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int WIDTH_MIN       = 2;
  localparam int WIDTH_MAX       = 16;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INIT = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
    logic [WIDTH_MAX-1:0] b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Highest count value; the range OFFSET..maxc is symmetric so wrap is a one-bit gray step.
  function automatic int maxc(input int width, input int offset);
    return (1 << width) - 1 - offset;
  endfunction

endpackage

// File: rtl/gray_count_chan.sv
// rtl/gray_count_chan.sv - one gray counter channel: counter, gray register, delay pipeline, wrap pulse
// Optional gray-step checker enabled by GRAY_COUNT_BANK_CHECK_EN.
module gray_count_chan
  import gray_count_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OFFSET      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             init,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] offset_count,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_d,
  output logic             wrap,
  output logic             gray_err
);

  localparam logic [WIDTH-1:0]     OFF_V         = WIDTH'(OFFSET);
  localparam logic [WIDTH-1:0]     MAXC_V        = WIDTH'(maxc(WIDTH, OFFSET));
  localparam logic [WIDTH_MAX-1:0] GRAY_OFF_FULL = bin2gray(WIDTH_MAX'(OFFSET));
  localparam logic [WIDTH-1:0]     GRAY_OFF      = GRAY_OFF_FULL[WIDTH-1:0];

  step_e            step;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_q;
  logic             wrap_nxt;

  always_comb begin
    step = STEP_HOLD;
    if (init) begin
      step = STEP_INIT;
    end else if (en) begin
      step = dir ? STEP_UP : STEP_DOWN;
    end
  end

  always_comb begin
    count_nxt = count_q;
    wrap_nxt  = 1'b0;
    case (step)
      STEP_INIT: count_nxt = OFF_V;
      STEP_UP: begin
        if (count_q == MAXC_V) begin
          count_nxt = OFF_V;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_q + WIDTH'(1);
        end
      end
      STEP_DOWN: begin
        if (count_q == OFF_V) begin
          count_nxt = MAXC_V;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_q - WIDTH'(1);
        end
      end
      default: count_nxt = count_q;
    endcase
    // Gray is derived from the next-state count so the registered gray output never glitches.
    gray_nxt = count_nxt ^ (count_nxt >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= OFF_V;
      gray_q  <= GRAY_OFF;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      gray_q  <= gray_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign count        = count_q;
  assign offset_count = count_q - OFF_V;
  assign gray         = gray_q;
  assign wrap         = wrap_q;

  if (SYNC_STAGES == 0) begin : g_no_pipe
    assign gray_d = gray_q;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe [SYNC_STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          pipe[i] <= GRAY_OFF;
        end
      end else begin
        pipe[0] <= gray_q;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign gray_d = pipe[SYNC_STAGES-1];
  end

`ifdef GRAY_COUNT_BANK_CHECK_EN
  logic [WIDTH-1:0] gray_prev;
  logic [WIDTH-1:0] gray_diff;
  logic             init_q;
  logic             err_q;

  assign gray_diff = gray_q ^ gray_prev;

  // init_q marks values produced by a deliberate reinitialise, which may jump several bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_prev <= GRAY_OFF;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      gray_prev <= gray_q;
      init_q    <= init;
      if (((gray_diff & (gray_diff - WIDTH'(1))) != '0) && !init_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign gray_err = err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: rtl/gray_count_bank.sv
// rtl/gray_count_bank.sv - NUM_CH independent up/down gray counters with delayed gray and wrap pulses
// Optional gray-step checker enabled by GRAY_COUNT_BANK_CHECK_EN.
module gray_count_bank
  import gray_count_bank_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int OFFSET      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       init_i,
  input  logic [NUM_CH-1:0]       dir_i,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH*WIDTH-1:0] offset_count_o,
  output logic [NUM_CH*WIDTH-1:0] gray_o,
  output logic [NUM_CH*WIDTH-1:0] gray_d_o,
  output logic [NUM_CH-1:0]       wrap_o,
  output logic [NUM_CH-1:0]       gray_err_o
);

  if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("gray_count_bank: NUM_CH %0d out of range 1..%0d", NUM_CH, NUM_CH_MAX);
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gray_count_bank: WIDTH %0d out of range %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (OFFSET < 0 || OFFSET >= (1 << (WIDTH - 1))) begin : g_bad_offset
    $error("gray_count_bank: OFFSET %0d must be below 2^(WIDTH-1)", OFFSET);
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("gray_count_bank: SYNC_STAGES %0d exceeds %0d", SYNC_STAGES, SYNC_STAGES_MAX);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gray_count_chan #(
      .WIDTH       (WIDTH),
      .OFFSET      (OFFSET),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .en           (en_i[c]),
      .init         (init_i[c]),
      .dir          (dir_i[c]),
      .count        (count_o[c*WIDTH +: WIDTH]),
      .offset_count (offset_count_o[c*WIDTH +: WIDTH]),
      .gray         (gray_o[c*WIDTH +: WIDTH]),
      .gray_d       (gray_d_o[c*WIDTH +: WIDTH]),
      .wrap         (wrap_o[c]),
      .gray_err     (gray_err_o[c])
    );
  end

endmodule

// File: tb/tb_gray_count_bank.sv
// tb/tb_gray_count_bank.sv - directed self-checking bench for gray_count_bank (WIDTH=4, OFFSET=3, SYNC_STAGES=3)
module tb_gray_count_bank;

  localparam int NUM_CH      = 4;
  localparam int WIDTH       = 4;
  localparam int OFFSET      = 3;
  localparam int SYNC_STAGES = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       init_i;
  logic [NUM_CH-1:0]       dir_i;
  logic [NUM_CH*WIDTH-1:0] count_o;
  logic [NUM_CH*WIDTH-1:0] offset_count_o;
  logic [NUM_CH*WIDTH-1:0] gray_o;
  logic [NUM_CH*WIDTH-1:0] gray_d_o;
  logic [NUM_CH-1:0]       wrap_o;
  logic [NUM_CH-1:0]       gray_err_o;

  int checks = 0;
  int errors = 0;

  // Counts 4..12 then wrap to 3, and gray(b) = b ^ (b >> 1) for each.
  logic [3:0] up_cnt  [10] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h3};
  logic [3:0] up_gray [10] = '{4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'h2};

  always #5 clk = ~clk;

  gray_count_bank #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .OFFSET      (OFFSET),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en_i),
    .init_i         (init_i),
    .dir_i          (dir_i),
    .count_o        (count_o),
    .offset_count_o (offset_count_o),
    .gray_o         (gray_o),
    .gray_d_o       (gray_d_o),
    .wrap_o         (wrap_o),
    .gray_err_o     (gray_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ch(input logic [15:0] v, input int c);
    return v[c*4 +: 4];
  endfunction

  initial begin
    logic [3:0] prev_g;

    rst = 1'b1; en_i = '0; init_i = '0; dir_i = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_count",  count_o,        16'h3333);
    check("rst_offset", offset_count_o, 16'h0000);
    check("rst_gray",   gray_o,         16'h2222);
    check("rst_gray_d", gray_d_o,       16'h2222);
    check("rst_wrap",   wrap_o,         4'h0);
    check("rst_err",    gray_err_o,     4'h0);

    // ch0 counts up through MAXC=12 and wraps to OFFSET=3
    en_i = 4'b0001; dir_i = 4'b0001;
    prev_g = 4'h2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("up_cnt[%0d]", i),  ch(count_o, 0), up_cnt[i]);
      check($sformatf("up_gray[%0d]", i), ch(gray_o, 0),  up_gray[i]);
      check($sformatf("up_wrap[%0d]", i), wrap_o, (i == 9) ? 4'b0001 : 4'b0000);
      check($sformatf("up_onebit[%0d]", i), $countones(ch(gray_o, 0) ^ prev_g), 1);
      prev_g = ch(gray_o, 0);
    end
    check("up_others", count_o[15:4], 12'h333);
    en_i = '0;
    tick();
    check("hold_cnt",  ch(count_o, 0), 4'h3);
    check("hold_wrap", wrap_o, 4'h0);

    // ch1 counts down from OFFSET and wraps to MAXC
    en_i = 4'b0010; dir_i = 4'b0000;
    tick();
    check("dn_cnt",    ch(count_o, 1),        4'hC);
    check("dn_wrap",   wrap_o,                4'b0010);
    check("dn_offset", ch(offset_count_o, 1), 4'h9);
    check("dn_gray",   ch(gray_o, 1),         4'hA);
    en_i = '0;

    // direction change on consecutive enabled cycles
    en_i = 4'b0001; dir_i = 4'b0001;
    tick();
    check("dc_up", ch(count_o, 0), 4'h4);
    dir_i = 4'b0000;
    tick();
    check("dc_dn",      ch(count_o, 0), 4'h3);
    check("dc_dn_gray", ch(gray_o, 0),  4'h2);
    check("dc_dn_wrap", wrap_o,         4'h0);
    tick();
    check("dc_wrap_cnt", ch(count_o, 0), 4'hC);
    check("dc_wrap",     wrap_o,         4'b0001);
    en_i = '0;
    tick(); tick(); tick(); tick();
    check("settled_gray_d", gray_d_o, 16'h22AA);

    // single step on ch2: gray_o moves after 1 edge, gray_d_o after 4
    en_i = 4'b0100; dir_i = 4'b0100;
    tick();
    en_i = '0;
    check("pipe_gray",    ch(gray_o, 2),   4'h6);
    check("pipe_gd1",     ch(gray_d_o, 2), 4'h2);
    tick();
    check("pipe_gd2",     ch(gray_d_o, 2), 4'h2);
    tick();
    check("pipe_gd3",     ch(gray_d_o, 2), 4'h2);
    tick();
    check("pipe_gd4",     ch(gray_d_o, 2), 4'h6);

    // init beats en on ch2 while ch3 counts independently
    init_i = 4'b0100; en_i = 4'b1100; dir_i = 4'b1100;
    tick();
    check("prio_ch2",  ch(count_o, 2), 4'h3);
    check("prio_wrap", wrap_o,         4'h0);
    check("prio_ch3",  ch(count_o, 3), 4'h4);
    check("prio_ch01", count_o[7:0],   8'hCC);
    init_i = '0; en_i = 4'b1000;
    tick();
    check("indep_ch3", ch(count_o, 3), 4'h5);
    check("indep_ch2", ch(count_o, 2), 4'h3);

    // reset mid-count clears everything on the next edge
    rst = 1'b1;
    tick();
    check("mid_rst_count",  count_o,        16'h3333);
    check("mid_rst_gray",   gray_o,         16'h2222);
    check("mid_rst_gray_d", gray_d_o,       16'h2222);
    check("mid_rst_offset", offset_count_o, 16'h0000);
    check("mid_rst_wrap",   wrap_o,         4'h0);
    rst = 1'b0; en_i = '0; dir_i = '0;
    tick();

`ifdef GRAY_COUNT_BANK_CHECK_EN
    en_i = 4'b0001; dir_i = 4'b0001;
    tick(); tick();
    en_i = '0;
    check("chk_pre_cnt", ch(count_o, 0), 4'h5);
    force dut.g_ch[0].u_chan.count_q = 4'd9;
    tick();
    release dut.g_ch[0].u_chan.count_q;
    tick(); tick();
    check("chk_jump_cnt", ch(count_o, 0), 4'h9);
    check("chk_err_set",  gray_err_o,     4'b0001);
    init_i = 4'b0001;
    tick();
    init_i = '0;
    tick(); tick();
    check("chk_err_sticky", gray_err_o, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("chk_err_rst", gray_err_o, 4'h0);
    en_i = 4'b0001; dir_i = 4'b0001;
    tick(); tick(); tick();
    en_i = '0;
    check("chk_pre_init", ch(count_o, 0), 4'h6);
    init_i = 4'b0001;
    tick();
    init_i = '0;
    tick(); tick();
    check("chk_init_cnt", ch(count_o, 0), 4'h3);
    check("chk_init_err", gray_err_o,     4'h0);
`else
    check("err_tied", gray_err_o, 4'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_count_bank.md
Name: gray_count_bank

Overview:
- Multi-channel, single-clock, gray-coded counter bank. Next generation of the team's gray counter/synchroniser family.
- Generalised to NUM_CH independent channels with per-channel up/down direction and offset-folded gray range.
- Adds a configurable gray delay pipeline, which models destination-side sync stages, plus per-channel wrap pulses.
- Used by FIFO pointer logic and multi-queue credit trackers feeding downstream CDC synchronisers.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- WIDTH, 8, counter width in bits (2..16).
- OFFSET, 0, lowest count value. Legal range is 0..2^(WIDTH-1)-1. Highest count value MAXC = 2^WIDTH-1-OFFSET.
- SYNC_STAGES, 2, register stages on gray_d_o (0..4). 0 means gray_d_o equals gray_o.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- en_i, in, NUM_CH: per-channel count enable.
- init_i, in, NUM_CH: per-channel synchronous reinitialise to OFFSET.
- dir_i, in, NUM_CH: per-channel direction. 1 = up, 0 = down.
- count_o, out, NUM_CH*WIDTH: registered binary count. Channel c occupies bits [c*WIDTH +: WIDTH].
- offset_count_o, out, NUM_CH*WIDTH: count_o minus OFFSET, zero-extended.
- gray_o, out, NUM_CH*WIDTH: registered gray code of count_o.
- gray_d_o, out, NUM_CH*WIDTH: gray_o delayed SYNC_STAGES cycles.
- wrap_o, out, NUM_CH: one-cycle pulse, asserted in the same cycle that the wrapped count appears on count_o.
- gray_err_o, out, NUM_CH: sticky gray-step error flag (see Optional Feature).

Behaviour:
- Priority per channel: rst > init_i > en_i.
- Reset values:
  - count_o = OFFSET.
  - offset_count_o = 0.
  - gray_o = gray(OFFSET).
  - Every gray_d_o stage = gray(OFFSET).
  - wrap_o = 0.
  - gray_err_o = 0.
- Reset during counting takes effect on the next edge and clears all pipeline stages.
- init_i=1:
  - count <= OFFSET and wrap_o <= 0, regardless of en_i and dir_i.
  - The delay pipeline is not cleared; gray_d_o shows the jump SYNC_STAGES cycles later.
- en_i=1, dir_i=1 (up):
  - If count==MAXC: count <= OFFSET and wrap_o <= 1.
  - Otherwise count <= count+1.
- en_i=1, dir_i=0 (down):
  - If count==OFFSET: count <= MAXC and wrap_o <= 1.
  - Otherwise count <= count-1.
- en_i=0: count holds and wrap_o <= 0.
- Latency: count_o, gray_o and wrap_o change 1 cycle after the sampled en_i. gray_d_o lags gray_o by exactly SYNC_STAGES cycles.
- Gray code:
  - gray = b ^ (b>>1), computed on the next-state count and registered, so gray_o is glitch-free.
  - Because the range is symmetric (OFFSET..MAXC), each step, including wrap MAXC<->OFFSET, changes exactly one gray bit (the MSB at wrap).
- Direction change between consecutive enabled cycles is legal and still a single-bit gray step.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Width rules: all arithmetic is WIDTH-bit unsigned. offset_count_o range is 0..2^WIDTH-1-2*OFFSET.
- Elaboration-time check: OFFSET >= 2^(WIDTH-1) or SYNC_STAGES > 4 triggers $error.

Optional Feature:
- Macro GRAY_COUNT_BANK_CHECK_EN.
- Defined: per channel, gray_o is compared to its previous-cycle value. If more than one bit differs and init_i was 0 in the cycle that produced the current value, gray_err_o is set. The flag is sticky until rst.
- Not defined: the checker logic is omitted and gray_err_o is tied to 0. The port is always present.

Decomposition:
- Package gray_count_bank_pkg holds:
  - Functions bin2gray and gray2bin.
  - Function maxc(WIDTH, OFFSET).
  - Localparam limits: NUM_CH_MAX=16, SYNC_STAGES_MAX=4.
- One sub-module, gray_count_chan: a single channel covering counter, gray register, delay pipeline, wrap pulse and checker.
- Top level is a generate loop over NUM_CH plus port slicing.

Test Plan (defaults unless noted):
- Reset: rst=1 for 2 cycles, then hold en_i=0.
  - Required: count_o=0, gray_o=0, gray_d_o=0, wrap_o=0.
- Up count and wrap, WIDTH=4, OFFSET=3 (MAXC=12): ch0 en=1 dir=1 from 3.
  - Required: sequence 3..12, then 3; wrap_o pulses once with count_o=3.
  - Required: every gray_o step differs by one bit; gray(12)=4'b1010 -> gray(3)=4'b0010.
- Down wrap, OFFSET=3: ch1 dir=0 from 3.
  - Required: next count_o=12 with wrap_o=1; offset_count_o=9.
- Pipeline latency, SYNC_STAGES=3: single enabled step at cycle N.
  - Required: gray_o changes at N+1, gray_d_o at N+4.
- Priority and independence: same cycle has init_i=1 and en_i=1 on ch2, rst=0, ch3 counting.
  - Required: ch2 count_o=OFFSET, no wrap; ch3 unaffected.
  - Then rst=1 mid-count: all channels = OFFSET on the next edge.
- GRAY_COUNT_BANK_CHECK_EN:
  - Force a count jump 5->9 via init-free backdoor: gray_err_o[ch]=1 and stays 1 until rst.
  - A normal init jump does not set the flag.
